// File: rtl/ace_pkg.sv
// Shared ACE snoop types, encodings and the responder FSM states.
// Also holds the snoop-to-response decode used by the responder.
package ace_pkg;

  localparam int unsigned AceAddrWidth = 64;
  localparam int unsigned AceDataWidth = 64;
  localparam int unsigned CrWidth      = 5;

  // CR response bit positions
  localparam int unsigned CrDt  = 0;
  localparam int unsigned CrErr = 1;
  localparam int unsigned CrPd  = 2;
  localparam int unsigned CrIs  = 3;
  localparam int unsigned CrWu  = 4;

  typedef enum logic [3:0] {
    SnpReadOnce           = 4'b0000,
    SnpReadShared         = 4'b0001,
    SnpReadClean          = 4'b0010,
    SnpReadNotSharedDirty = 4'b0011,
    SnpReadUnique         = 4'b0111,
    SnpCleanShared        = 4'b1000,
    SnpCleanInvalid       = 4'b1001,
    SnpMakeInvalid        = 4'b1101
  } ac_snoop_e;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWait,
    StUpdate,
    StCr,
    StCd
  } snoop_state_e;

  typedef struct packed {
    logic [AceAddrWidth-1:0] addr;
    logic [3:0]              snoop;
    logic [2:0]              prot;
  } ac_chan_t;

  typedef struct packed {
    logic [AceDataWidth-1:0] data;
    logic                    last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic               ac_ready;
    logic               cr_valid;
    logic [CrWidth-1:0] cr_resp;
    logic               cd_valid;
    cd_chan_t           cd;
  } snoop_resp_t;

  typedef struct packed {
    logic [CrWidth-1:0] cr_resp;
    logic               inval;
    logic               clean;
    logic               share;
  } snoop_dec_t;

  function automatic snoop_dec_t snoop_decode(
    input logic [3:0] snoop,
    input logic       hit,
    input logic       dirty,
    input logic       shared
  );
    snoop_dec_t d;
    logic       known;
    d     = '0;
    known = 1'b1;
    if (hit) begin
      case (snoop)
        SnpReadOnce: begin
          d.cr_resp[CrDt] = 1'b1;
          d.cr_resp[CrIs] = 1'b1;
        end
        SnpReadShared, SnpReadClean, SnpReadNotSharedDirty: begin
          d.cr_resp[CrDt] = 1'b1;
          d.cr_resp[CrIs] = 1'b1;
          d.cr_resp[CrPd] = dirty;
          d.clean         = dirty;
          d.share         = 1'b1;
        end
        SnpReadUnique: begin
          d.cr_resp[CrDt] = 1'b1;
          d.cr_resp[CrPd] = dirty;
          d.inval         = 1'b1;
        end
        SnpCleanInvalid: begin
          d.cr_resp[CrDt] = dirty;
          d.cr_resp[CrPd] = dirty;
          d.inval         = 1'b1;
        end
        SnpCleanShared: begin
          d.cr_resp[CrDt] = dirty;
          d.cr_resp[CrPd] = dirty;
          d.cr_resp[CrIs] = 1'b1;
          d.clean         = dirty;
        end
        SnpMakeInvalid: begin
          d.inval = 1'b1;
        end
        default: known = 1'b0;
      endcase
      // Unknown encodings answer with an all-zero response
      d.cr_resp[CrWu] = known & ~shared;
    end
    return d;
  endfunction

endpackage

// File: rtl/ace_line_serializer.sv
// Holds one cache line and streams it out as DataWidth beats.
// Ports: load_i/line_i capture, start_i begins, valid/ready/data/last, done_o.
module ace_line_serializer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [LineWidth-1:0] line_i,
  input  logic                 start_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam int unsigned Beats = LineWidth / DataWidth;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  logic [LineWidth-1:0] r_line;
  logic [CntW-1:0]      r_cnt;
  logic                 r_active;
  logic                 w_fire;
  logic                 w_last;

  assign w_fire  = r_active & ready_i;
  assign w_last  = (r_cnt == LastBeat);
  assign valid_o = r_active;
  assign last_o  = r_active & w_last;
  assign data_o  = r_line[32'(r_cnt) * DataWidth +: DataWidth];
  assign done_o  = w_fire & w_last;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      r_line <= line_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (start_i) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC in, lookup/update, CR out, CD line out.
// Ports: snoop_req_i/snoop_resp_o bundles, lookup_* and upd_* cache ports.
module ace_snoop_responder
  import ace_pkg::*;
#(
  parameter int unsigned AddrWidth = AceAddrWidth,
  parameter int unsigned DataWidth = AceDataWidth,
  parameter int unsigned LineWidth = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  snoop_req_t           snoop_req_i,
  output snoop_resp_t          snoop_resp_o,
  output logic                 lookup_req_o,
  output logic [AddrWidth-1:0] lookup_addr_o,
  input  logic                 lookup_gnt_i,
  input  logic                 lookup_valid_i,
  input  logic                 lookup_hit_i,
  input  logic                 lookup_dirty_i,
  input  logic                 lookup_shared_i,
  input  logic [LineWidth-1:0] lookup_data_i,
  output logic                 upd_req_o,
  output logic                 upd_inval_o,
  output logic                 upd_clean_o,
  output logic                 upd_share_o,
  input  logic                 upd_gnt_i
);

  localparam logic [AddrWidth-1:0] LineMask =
    AddrWidth'(LineWidth / 8 - 1);

  snoop_state_e         r_state;
  logic                 r_ac_ready;
  logic [AddrWidth-1:0] r_addr;
  logic [3:0]           r_snoop;
  logic                 r_lookup_req;
  logic                 r_upd_req;
  logic                 r_upd_inval;
  logic                 r_upd_clean;
  logic                 r_upd_share;
  logic                 r_cr_valid;
  logic [CrWidth-1:0]   r_cr_resp;

  snoop_dec_t           w_dec;
  logic                 w_ac_fire;
  logic                 w_cr_fire;
  logic                 w_ser_load;
  logic                 w_ser_start;
  logic                 w_ser_done;
  logic                 w_cd_valid;
  logic [DataWidth-1:0] w_cd_data;
  logic                 w_cd_last;
  logic                 w_unused;

  assign w_dec = snoop_decode(r_snoop, lookup_hit_i,
                              lookup_dirty_i, lookup_shared_i);

  assign w_ac_fire   = r_ac_ready & snoop_req_i.ac_valid;
  assign w_cr_fire   = r_cr_valid & snoop_req_i.cr_ready;
  assign w_ser_load  = (r_state == StWait) & lookup_valid_i;
  assign w_ser_start = w_cr_fire & r_cr_resp[CrDt];
  assign w_unused    = ^snoop_req_i.ac.prot;

  ace_line_serializer #(
    .DataWidth(DataWidth),
    .LineWidth(LineWidth)
  ) u_ser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_ser_load),
    .line_i (lookup_data_i),
    .start_i(w_ser_start),
    .valid_o(w_cd_valid),
    .ready_i(snoop_req_i.cd_ready),
    .data_o (w_cd_data),
    .last_o (w_cd_last),
    .done_o (w_ser_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_ac_ready   <= 1'b0;
      r_addr       <= '0;
      r_snoop      <= '0;
      r_lookup_req <= 1'b0;
      r_upd_req    <= 1'b0;
      r_upd_inval  <= 1'b0;
      r_upd_clean  <= 1'b0;
      r_upd_share  <= 1'b0;
      r_cr_valid   <= 1'b0;
      r_cr_resp    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ac_fire) begin
            r_addr       <= snoop_req_i.ac.addr & ~LineMask;
            r_snoop      <= snoop_req_i.ac.snoop;
            r_ac_ready   <= 1'b0;
            r_lookup_req <= 1'b1;
            r_state      <= StLookup;
          end else begin
            r_ac_ready <= 1'b1;
          end
        end
        StLookup: begin
          if (lookup_gnt_i) begin
            r_lookup_req <= 1'b0;
            r_state      <= StWait;
          end
        end
        StWait: begin
          if (lookup_valid_i) begin
            r_cr_resp   <= w_dec.cr_resp;
            r_upd_inval <= w_dec.inval;
            r_upd_clean <= w_dec.clean;
            r_upd_share <= w_dec.share;
            // decode only raises flags on a hit
            if (w_dec.inval | w_dec.clean | w_dec.share) begin
              r_upd_req <= 1'b1;
              r_state   <= StUpdate;
            end else begin
              r_cr_valid <= 1'b1;
              r_state    <= StCr;
            end
          end
        end
        StUpdate: begin
          if (upd_gnt_i) begin
            r_upd_req  <= 1'b0;
            r_cr_valid <= 1'b1;
            r_state    <= StCr;
          end
        end
        StCr: begin
          if (w_cr_fire) begin
            r_cr_valid <= 1'b0;
            if (r_cr_resp[CrDt]) begin
              r_state <= StCd;
            end else begin
              r_ac_ready <= 1'b1;
              r_state    <= StIdle;
            end
          end
        end
        StCd: begin
          if (w_ser_done) begin
            r_ac_ready <= 1'b1;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign lookup_req_o  = r_lookup_req;
  assign lookup_addr_o = r_addr;
  assign upd_req_o     = r_upd_req;
  assign upd_inval_o   = r_upd_inval;
  assign upd_clean_o   = r_upd_clean;
  assign upd_share_o   = r_upd_share;

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = r_ac_ready;
    snoop_resp_o.cr_valid = r_cr_valid;
    snoop_resp_o.cr_resp  = r_cr_resp;
    snoop_resp_o.cd_valid = w_cd_valid;
    snoop_resp_o.cd.data  = w_cd_data;
    snoop_resp_o.cd.last  = w_cd_last;
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder.
// Drives AC/lookup/update/CR/CD by hand and checks hand-computed results.
module tb_ace_snoop_responder;
  import ace_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  snoop_req_t  req;
  snoop_resp_t resp;
  logic        lk_req;
  logic [63:0] lk_addr;
  logic        lk_gnt, lk_valid, lk_hit, lk_dirty, lk_shared;
  logic [511:0] lk_data;
  logic        upd_req, upd_inval, upd_clean, upd_share, upd_gnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // observations of the most recent transaction
  bit          o_tmo, o_stab, o_order, o_early, o_lkerr;
  bit          o_upd, o_cr_seen;
  logic [2:0]  o_flags;
  logic [4:0]  o_cr;
  logic [63:0] o_addr;
  logic [63:0] o_beats [8];
  int          o_n, o_nlast, o_lastidx, o_lat, o_gap;
  logic [4:0]  o_rst_sig;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .snoop_req_i    (req),
    .snoop_resp_o   (resp),
    .lookup_req_o   (lk_req),
    .lookup_addr_o  (lk_addr),
    .lookup_gnt_i   (lk_gnt),
    .lookup_valid_i (lk_valid),
    .lookup_hit_i   (lk_hit),
    .lookup_dirty_i (lk_dirty),
    .lookup_shared_i(lk_shared),
    .lookup_data_i  (lk_data),
    .upd_req_o      (upd_req),
    .upd_inval_o    (upd_inval),
    .upd_clean_o    (upd_clean),
    .upd_share_o    (upd_share),
    .upd_gnt_i      (upd_gnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [511:0] mk_line(input logic [7:0] base);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[8*i +: 8] = base + 8'(i);
    return l;
  endfunction

  task automatic do_snoop(
    input logic [63:0] addr,
    input logic [3:0]  snp,
    input logic        hit, dirty, shared,
    input logic [7:0]  base,
    input int          gnt_dly, upd_dly,
    input bit          stall, hold_next,
    input int          abort_at,
    input logic [63:0] nxt_addr,
    input logic [3:0]  nxt_snp
  );
    int g, lat, upd_wait, cr_end;
    bit cr_done, fin, have_prev, tog, crhs;
    logic [63:0] p_data;
    logic        p_last;
    o_tmo = 0; o_stab = 0; o_order = 0; o_early = 0; o_lkerr = 0;
    o_upd = 0; o_cr_seen = 0; o_flags = '0; o_cr = '0; o_addr = '0;
    o_n = 0; o_nlast = 0; o_lastidx = -1; o_lat = -1; o_gap = -1;
    o_rst_sig = '1;
    for (int i = 0; i < 8; i++) o_beats[i] = '0;
    g = 0;
    while (!resp.ac_ready && g < 50) begin step(); g++; end
    if (!resp.ac_ready) begin o_tmo = 1; return; end
    req.ac_valid = 1'b1;
    req.ac.addr = addr;
    req.ac.snoop = snp;
    req.ac.prot = 3'b010;
    step();
    lat = 1;
    if (hold_next) begin
      req.ac.addr = nxt_addr;
      req.ac.snoop = nxt_snp;
    end else begin
      req.ac_valid = 1'b0;
    end
    if (!lk_req) o_lkerr = 1;
    o_addr = lk_addr;
    for (int i = 0; i < gnt_dly; i++) begin
      if (!lk_req) o_stab = 1;
      if (resp.ac_ready) o_early = 1;
      step(); lat++;
    end
    lk_gnt = 1'b1;
    step(); lat++;
    lk_gnt = 1'b0;
    if (resp.ac_ready) o_early = 1;
    lk_valid = 1'b1;
    lk_hit = hit; lk_dirty = dirty; lk_shared = shared;
    lk_data = mk_line(base);
    step(); lat++;
    lk_valid = 1'b0;
    lk_data = '0;
    upd_wait = 0; cr_done = 0; fin = 0; have_prev = 0; tog = 0;
    cr_end = 0; g = 0;
    while (!fin && g < 300) begin
      crhs = 0;
      if (resp.ac_ready) begin
        if (cr_done) begin fin = 1; o_gap = lat - cr_end + 1; end
        else o_early = 1;
      end
      if (!fin) begin
        if (upd_req) begin
          if (!o_upd) begin
            o_upd = 1;
            o_flags = {upd_inval, upd_clean, upd_share};
          end else if (o_flags !== {upd_inval, upd_clean, upd_share}) begin
            o_stab = 1;
          end
          if (o_cr_seen) o_order = 1;
          upd_gnt = (upd_wait >= upd_dly);
          upd_wait++;
        end else upd_gnt = 1'b0;
        if (resp.cr_valid) begin
          if (!o_cr_seen) begin
            o_cr_seen = 1; o_cr = resp.cr_resp; o_lat = lat;
          end else if (resp.cr_resp !== o_cr) o_stab = 1;
          req.cr_ready = 1'b1;
          crhs = 1;
        end else req.cr_ready = 1'b0;
        if (resp.cd_valid) begin
          if (!cr_done) o_order = 1;
          if (have_prev && (resp.cd.data !== p_data ||
              resp.cd.last !== p_last)) o_stab = 1;
          if (abort_at >= 0 && o_n == abort_at) begin
            req.cd_ready = 1'b0;
            rst = 1'b1;
            step();
            o_rst_sig = {resp.cd_valid, resp.cr_valid, upd_req,
                         lk_req, resp.ac_ready};
            rst = 1'b0;
            req.cr_ready = 1'b0;
            upd_gnt = 1'b0;
            return;
          end
          if (stall) begin tog = ~tog; req.cd_ready = ~tog; end
          else req.cd_ready = 1'b1;
          if (req.cd_ready) begin
            if (o_n < 8) o_beats[o_n] = resp.cd.data;
            if (resp.cd.last) begin o_nlast++; o_lastidx = o_n; end
            o_n++;
            have_prev = 0;
          end else begin
            have_prev = 1;
            p_data = resp.cd.data;
            p_last = resp.cd.last;
          end
        end else req.cd_ready = 1'b0;
        step(); lat++; g++;
        if (crhs) begin cr_done = 1; cr_end = lat; end
      end
    end
    if (!fin) o_tmo = 1;
    req.cr_ready = 1'b0;
    req.cd_ready = 1'b0;
    upd_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({resp.ac_ready, resp.cr_valid, resp.cd_valid, lk_req, upd_req}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b exp 00000",
               {resp.ac_ready, resp.cr_valid, resp.cd_valid, lk_req, upd_req});
    end
    rst = 1'b0;
    step(); step();
    checks++;
    if (resp.ac_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: got %b exp 1", resp.ac_ready);
    end
  endtask

  task automatic test_read_shared();
    do_snoop(64'h1040, SnpReadShared, 1, 1, 0, 8'h00, 0, 0, 0, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_stab || o_order || o_early || o_lkerr) begin
      errors++;
      $display("FAIL rs_proto: tmo=%0d stab=%0d ord=%0d early=%0d lk=%0d exp 0",
               o_tmo, o_stab, o_order, o_early, o_lkerr);
    end
    checks++;
    if (o_addr !== 64'h1040) begin
      errors++; $display("FAIL rs_addr: got %h exp 1040", o_addr);
    end
    checks++;
    if ({o_upd, o_flags} !== 4'b1011) begin
      errors++; $display("FAIL rs_upd: got %b exp 1011", {o_upd, o_flags});
    end
    // line stays resident as shared, so IsShared is set with PassDirty
    checks++;
    if (o_cr !== 5'b11101) begin
      errors++; $display("FAIL rs_cr: got %b exp 11101", o_cr);
    end
    checks++;
    if (o_lat !== 4) begin
      errors++; $display("FAIL rs_latency: got %0d exp 4", o_lat);
    end
    checks++;
    if (o_n !== 8 || o_nlast !== 1 || o_lastidx !== 7) begin
      errors++;
      $display("FAIL rs_beats: n=%0d last=%0d at %0d exp 8 1 7",
               o_n, o_nlast, o_lastidx);
    end
    checks++;
    if (o_beats[0] !== 64'h0706050403020100) begin
      errors++; $display("FAIL rs_beat0: got %h", o_beats[0]);
    end
    checks++;
    if (o_beats[7] !== 64'h3F3E3D3C3B3A3938) begin
      errors++; $display("FAIL rs_beat7: got %h", o_beats[7]);
    end
  endtask

  task automatic test_read_unique();
    do_snoop(64'h2077, SnpReadUnique, 1, 0, 1, 8'h80, 0, 0, 0, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_stab || o_order || o_early) begin
      errors++; $display("FAIL ru_proto: tmo=%0d stab=%0d ord=%0d early=%0d",
                         o_tmo, o_stab, o_order, o_early);
    end
    checks++;
    if (o_addr !== 64'h2040) begin
      errors++; $display("FAIL ru_align: got %h exp 2040", o_addr);
    end
    checks++;
    if ({o_upd, o_flags} !== 4'b1100 || o_cr !== 5'b00001) begin
      errors++; $display("FAIL ru_resp: upd %b cr %b exp 1100 00001",
                         {o_upd, o_flags}, o_cr);
    end
    checks++;
    if (o_n !== 8 || o_beats[3] !== 64'h9F9E9D9C9B9A9998) begin
      errors++; $display("FAIL ru_data: n=%0d beat3 %h", o_n, o_beats[3]);
    end
  endtask

  task automatic test_miss();
    do_snoop(64'h5000, SnpMakeInvalid, 0, 0, 0, 8'h00, 0, 0, 0, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_upd || o_cr !== 5'b0 || o_n !== 0) begin
      errors++; $display("FAIL miss: tmo=%0d upd=%0d cr=%b beats=%0d exp 0",
                         o_tmo, o_upd, o_cr, o_n);
    end
    checks++;
    if (o_lat !== 3 || o_gap !== 1) begin
      errors++; $display("FAIL miss_timing: lat=%0d gap=%0d exp 3 1",
                         o_lat, o_gap);
    end
    // clean hit on CleanShared: no data, no update
    do_snoop(64'h5040, SnpCleanShared, 1, 0, 0, 8'h00, 0, 0, 0, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_upd || o_cr !== 5'b11000 || o_n !== 0) begin
      errors++; $display("FAIL cs_clean: upd=%0d cr=%b beats=%0d exp 0 11000 0",
                         o_upd, o_cr, o_n);
    end
  endtask

  task automatic test_stalls();
    do_snoop(64'h6000, SnpCleanInvalid, 1, 1, 0, 8'h10, 3, 3, 1, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_stab || o_order) begin
      errors++; $display("FAIL st_stable: tmo=%0d stab=%0d ord=%0d exp 0",
                         o_tmo, o_stab, o_order);
    end
    checks++;
    if ({o_upd, o_flags} !== 4'b1100 || o_cr !== 5'b10101) begin
      errors++; $display("FAIL st_resp: upd %b cr %b exp 1100 10101",
                         {o_upd, o_flags}, o_cr);
    end
    checks++;
    if (o_n !== 8 || o_nlast !== 1 || o_lastidx !== 7) begin
      errors++; $display("FAIL st_beats: n=%0d last=%0d at %0d exp 8 1 7",
                         o_n, o_nlast, o_lastidx);
    end
    checks++;
    if (o_beats[0] !== 64'h1716151413121110 ||
        o_beats[5] !== 64'h3F3E3D3C3B3A3938) begin
      errors++; $display("FAIL st_data: b0 %h b5 %h", o_beats[0], o_beats[5]);
    end
  endtask

  task automatic test_back_to_back();
    do_snoop(64'h7000, SnpReadOnce, 1, 0, 0, 8'hC0, 0, 0, 0, 1, -1,
             64'h3000, SnpMakeInvalid);
    checks++;
    if (o_tmo || o_early || o_upd || o_cr !== 5'b11001) begin
      errors++; $display("FAIL b2b_first: tmo=%0d early=%0d upd=%0d cr=%b",
                         o_tmo, o_early, o_upd, o_cr);
    end
    checks++;
    if (o_n !== 8 || o_beats[7] !== 64'hFFFEFDFCFBFAF9F8) begin
      errors++; $display("FAIL b2b_data: n=%0d b7 %h", o_n, o_beats[7]);
    end
    do_snoop(64'h3000, SnpMakeInvalid, 1, 1, 0, 8'h00, 0, 0, 0, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_addr !== 64'h3000 || o_cr !== 5'b10000 ||
        {o_upd, o_flags} !== 4'b1100 || o_n !== 0) begin
      errors++; $display("FAIL b2b_second: addr %h cr %b upd %b n=%0d",
                         o_addr, o_cr, {o_upd, o_flags}, o_n);
    end
  endtask

  task automatic test_reset_mid_cd();
    do_snoop(64'h8000, SnpReadUnique, 1, 1, 0, 8'h00, 0, 0, 0, 0, 4,
             '0, '0);
    checks++;
    if (o_n !== 4 || o_rst_sig !== 5'b0) begin
      errors++; $display("FAIL rst_cd: n=%0d outs %b exp 4 00000",
                         o_n, o_rst_sig);
    end
    do_snoop(64'h9000, SnpReadOnce, 1, 0, 1, 8'h40, 0, 0, 0, 0, -1,
             '0, '0);
    checks++;
    if (o_tmo || o_n !== 8 || o_cr !== 5'b01001 ||
        o_beats[0] !== 64'h4746454443424140) begin
      errors++; $display("FAIL rst_restart: n=%0d cr %b b0 %h",
                         o_n, o_cr, o_beats[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    lk_gnt = 0; lk_valid = 0; lk_hit = 0; lk_dirty = 0; lk_shared = 0;
    lk_data = '0;
    upd_gnt = 0;
    test_reset();
    test_read_shared();
    test_read_unique();
    test_miss();
    test_stalls();
    test_back_to_back();
    test_reset_mid_cd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
